arith_unit: RTL and testbench

// - Datapath of the arithmetic device: registers A, B, C plus adder, driven by the

---
 rtl/arith_unit_pkg.sv | 13 +
 rtl/arith_unit_adder.sv | 23 ++
 rtl/arith_unit.sv | 117 +++++++++++
 tb/tb_arith_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_unit_pkg.sv
// Shared constants and helpers for the arithmetic-device datapath.
// Bit 0 is the MSB/sign bit. Bit WIDTH-1 is the LSB.
package arith_unit_pkg;

  localparam int AU_WIDTH = 31;
  localparam int SIGN_BIT = 0;

  // True when two or more writer requests are asserted together.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/arith_unit_adder.sv
// WIDTH-bit adder for the A+B path.
// When END_AROUND_CARRY_EN is defined, the carry is fed back into the LSB.
module arith_adder #(
  parameter int WIDTH = 31
) (
  input  logic [0:WIDTH-1] i_a,
  input  logic [0:WIDTH-1] i_b,
  output logic [0:WIDTH-1] o_sum,
  output logic             o_cy
);

  logic [0:WIDTH-1] w_raw;

  assign {o_cy, w_raw} = {1'b0, i_a} + {1'b0, i_b};

`ifdef END_AROUND_CARRY_EN
  // Ones'-complement sum. The reported carry stays the raw carry of A+B.
  assign o_sum = w_raw + {{(WIDTH-1){1'b0}}, o_cy};
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/arith_unit.sv
// Arithmetic device datapath: registers A/B/C driven by one-cycle command pulses.
// The optional END_AROUND_CARRY_EN macro is handled inside arith_adder.
module arith_unit
  import arith_unit_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             do_clear_a_to_au,
  input  logic             do_clear_b_to_au,
  input  logic             do_clear_c_to_au,
  input  logic             do_not_a_to_au,
  input  logic             do_not_b_to_au,
  input  logic             do_sum_to_au,
  input  logic             do_and_to_au,
  input  logic             do_set_c_30_to_au,
  input  logic             do_left_shift_b_to_au,
  input  logic             do_left_shift_c_to_au,
  input  logic             do_left_shift_c29_to_au,
  input  logic             do_right_shift_bc_to_au,
  input  logic             do_move_c_to_a_to_au,
  input  logic             do_move_c_to_b_to_au,
  input  logic             do_move_b_to_c_to_au,
  input  logic             load_a_from_mem,
  input  logic [0:WIDTH-1] mem_data_from_mem,
  input  logic             io_bit_from_io,
  output logic             carry_out_from_au,
  output logic             reg_c_30_from_au,
  output logic             reg_b_0_from_au,
  output logic [0:WIDTH-1] reg_c_to_mem,
  output logic             cmd_conflict_err
);

  localparam int LSB = WIDTH - 1;

  logic [0:WIDTH-1] r_a, r_b, r_c;
  logic             r_err;
  logic [0:WIDTH-1] w_a_nxt, w_b_nxt, w_c_nxt, w_sum;
  logic             w_cy, w_conflict;
  logic [7:0]       w_a_hits, w_b_hits, w_c_hits;

  arith_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_sum (w_sum),
    .o_cy  (w_cy)
  );

  // Priority muxes. Every source reads the pre-clock register values.
  always_comb begin
    w_a_nxt = r_a;
    if (do_clear_a_to_au)          w_a_nxt = '0;
    else if (load_a_from_mem)      w_a_nxt = mem_data_from_mem;
    else if (do_move_c_to_a_to_au) w_a_nxt = r_c;
    else if (do_not_a_to_au)       w_a_nxt = ~r_a;
  end

  always_comb begin
    w_b_nxt = r_b;
    if (do_clear_b_to_au)             w_b_nxt = '0;
    else if (do_move_c_to_b_to_au)    w_b_nxt = r_c;
    else if (do_not_b_to_au)          w_b_nxt = ~r_b;
    else if (do_sum_to_au)            w_b_nxt = w_sum;
    else if (do_left_shift_b_to_au)   w_b_nxt = {r_b[1:LSB], 1'b0};
    else if (do_right_shift_bc_to_au) w_b_nxt = {1'b0, r_b[0:LSB-1]};
  end

  always_comb begin
    w_c_nxt = r_c;
    if (do_clear_c_to_au)               w_c_nxt = '0;
    else if (do_move_b_to_c_to_au)      w_c_nxt = r_b;
    else if (do_and_to_au)              w_c_nxt = r_a & r_b;
    else if (do_left_shift_c29_to_au) begin
      // Divide step: the upper bits shift while the LSB is held,
      // unless set_c_30 forces the quotient bit.
      w_c_nxt[0:LSB-1] = r_c[1:LSB];
      if (do_set_c_30_to_au) w_c_nxt[LSB] = 1'b1;
    end
    else if (do_left_shift_c_to_au)   w_c_nxt = {r_c[1:LSB], io_bit_from_io};
    else if (do_right_shift_bc_to_au) w_c_nxt = {r_b[LSB], r_c[0:LSB-1]};
    else if (do_set_c_30_to_au)       w_c_nxt[LSB] = 1'b1;
  end

  // The set_c_30 and left_shift_c requests are exempt alongside left_shift_c29.
  assign w_a_hits = {4'b0, do_clear_a_to_au, load_a_from_mem, do_move_c_to_a_to_au,
                     do_not_a_to_au};
  assign w_b_hits = {2'b0, do_clear_b_to_au, do_move_c_to_b_to_au, do_not_b_to_au,
                     do_sum_to_au, do_left_shift_b_to_au, do_right_shift_bc_to_au};
  assign w_c_hits = {1'b0, do_clear_c_to_au, do_move_b_to_c_to_au, do_and_to_au,
                     do_left_shift_c29_to_au,
                     do_left_shift_c_to_au & ~do_left_shift_c29_to_au,
                     do_right_shift_bc_to_au,
                     do_set_c_30_to_au & ~do_left_shift_c29_to_au};
  assign w_conflict = multi_hot(w_a_hits) | multi_hot(w_b_hits) | multi_hot(w_c_hits);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_err <= 1'b0;
    end else begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
      r_c <= w_c_nxt;
      if (w_conflict) r_err <= 1'b1;
    end
  end

  assign carry_out_from_au = w_cy;
  assign reg_c_30_from_au  = r_c[LSB];
  assign reg_b_0_from_au   = r_b[SIGN_BIT];
  assign reg_c_to_mem      = r_c;
  assign cmd_conflict_err  = r_err;

endmodule

// File: tb/tb_arith_unit.sv
// Directed bench for arith_unit: hand-computed vectors checked with immediate assertions.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.
module tb_arith_unit;

  localparam int W = 31;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         clr_a, clr_b, clr_c, not_a, not_b, sum, and_c, set_c30;
  logic         ls_b, ls_c, ls_c29, rs_bc, mv_ca, mv_cb, mv_bc, ld_a;
  logic [W-1:0] mem_data;
  logic         io_bit;
  logic         carry, c30, b0, err;
  logic [W-1:0] c_out;
  logic [W-1:0] rd;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  arith_unit dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .do_clear_a_to_au        (clr_a),
    .do_clear_b_to_au        (clr_b),
    .do_clear_c_to_au        (clr_c),
    .do_not_a_to_au          (not_a),
    .do_not_b_to_au          (not_b),
    .do_sum_to_au            (sum),
    .do_and_to_au            (and_c),
    .do_set_c_30_to_au       (set_c30),
    .do_left_shift_b_to_au   (ls_b),
    .do_left_shift_c_to_au   (ls_c),
    .do_left_shift_c29_to_au (ls_c29),
    .do_right_shift_bc_to_au (rs_bc),
    .do_move_c_to_a_to_au    (mv_ca),
    .do_move_c_to_b_to_au    (mv_cb),
    .do_move_b_to_c_to_au    (mv_bc),
    .load_a_from_mem         (ld_a),
    .mem_data_from_mem       (mem_data),
    .io_bit_from_io          (io_bit),
    .carry_out_from_au       (carry),
    .reg_c_30_from_au        (c30),
    .reg_b_0_from_au         (b0),
    .reg_c_to_mem            (c_out),
    .cmd_conflict_err        (err)
  );

  task automatic idle_all();
    {clr_a, clr_b, clr_c, not_a, not_b, sum, and_c, set_c30} = '0;
    {ls_b, ls_c, ls_c29, rs_bc, mv_ca, mv_cb, mv_bc, ld_a}   = '0;
    io_bit = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [W-1:0] v);
    mem_data = v;
    ld_a = 1'b1;
    tick();
  endtask

  // B <= v by clearing B, loading A=v, then summing. A is left holding v.
  task automatic set_b(input logic [W-1:0] v);
    mem_data = v;
    ld_a = 1'b1;
    clr_b = 1'b1;
    tick();
    sum = 1'b1;
    tick();
  endtask

  task automatic set_c(input logic [W-1:0] v);
    set_b(v);
    mv_bc = 1'b1;
    tick();
  endtask

  // Reads B through C. This overwrites C.
  task automatic read_b(output logic [W-1:0] v);
    mv_bc = 1'b1;
    tick();
    v = c_out;
  endtask

  initial begin
    idle_all();
    mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c", 32'(c_out), 32'h0);
    chk("rst_b0", 32'(b0), 32'h0);
    chk("rst_c30", 32'(c30), 32'h0);
    chk("rst_cy", 32'(carry), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    resetn = 1'b1;
    tick();

    // Mid-cycle asynchronous reset with all three registers non-zero.
    set_c(31'h12345678);
    set_b(31'h40000000);
    load_a(31'h5A5A5A5A);
    chk("pre_rst_cy", 32'(carry), 32'h1);
    chk("pre_rst_b0", 32'(b0), 32'h1);
    chk("pre_rst_c", 32'(c_out), 32'h12345678);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_c", 32'(c_out), 32'h0);
    chk("async_rst_b0", 32'(b0), 32'h0);
    chk("async_rst_cy", 32'(carry), 32'h0);
    #2 resetn = 1'b1;
    not_b = 1'b1;
    tick();
    chk("async_rst_a_zero", 32'(carry), 32'h0);

    // Multiply step.
    set_c(31'h1);
    chk("mul_c30_pre", 32'(c30), 32'h1);
    clr_b = 1'b1;
    tick();
    rs_bc = 1'b1;
    tick();
    chk("mul_rs_c", 32'(c_out), 32'h0);
    chk("mul_rs_c30", 32'(c30), 32'h0);
    chk("mul_rs_b0", 32'(b0), 32'h0);
    set_b(31'h1);
    clr_c = 1'b1;
    tick();
    rs_bc = 1'b1;
    tick();
    chk("mul_rs_c_msb", 32'(c_out), 32'h40000000);
    read_b(rd);
    chk("mul_rs_b", 32'(rd), 32'h0);

    // Divide step and C shifts.
    set_c(31'h1);
    ls_c29 = 1'b1;
    set_c30 = 1'b1;
    tick();
    chk("div_step_c", 32'(c_out), 32'h3);
    ls_c29 = 1'b1;
    tick();
    chk("ls_c29_c", 32'(c_out), 32'h7);
    ls_c = 1'b1;
    io_bit = 1'b1;
    tick();
    chk("ls_c_io1", 32'(c_out), 32'hF);
    ls_c = 1'b1;
    tick();
    chk("ls_c_io0", 32'(c_out), 32'h1E);
    set_c30 = 1'b1;
    tick();
    chk("set_c30", 32'(c_out), 32'h1F);
    set_b(31'h20000000);
    chk("ls_b_b0_pre", 32'(b0), 32'h0);
    ls_b = 1'b1;
    tick();
    chk("ls_b_b0", 32'(b0), 32'h1);
    chk("div_no_err", 32'(err), 32'h0);

    // Adder.
    set_b(31'd5);
    load_a(31'd3);
    chk("sum_small_cy", 32'(carry), 32'h0);
    sum = 1'b1;
    tick();
    read_b(rd);
    chk("sum_small_b", 32'(rd), 32'd8);
    set_b(31'h7FFFFFFF);
    load_a(31'h7FFFFFFF);
    chk("sum_big_cy", 32'(carry), 32'h1);
    sum = 1'b1;
    tick();
    read_b(rd);
`ifdef END_AROUND_CARRY_EN
    chk("sum_big_b", 32'(rd), 32'h7FFFFFFF);
`else
    chk("sum_big_b", 32'(rd), 32'h7FFFFFFE);
`endif

    // AND and NOT.
    set_b(31'h00FF);
    load_a(31'h0F0F);
    and_c = 1'b1;
    tick();
    chk("and_c", 32'(c_out), 32'h000F);
    not_b = 1'b1;
    tick();
    not_a = 1'b1;
    tick();
    and_c = 1'b1;
    tick();
    chk("not_ab_and", 32'(c_out), 32'h7FFFF000);
    read_b(rd);
    chk("not_b", 32'(rd), 32'h7FFFFF00);

    // Swap B and C in one cycle.
    set_b(31'h22);
    mv_bc = 1'b1;
    tick();
    set_b(31'h11);
    mv_bc = 1'b1;
    mv_cb = 1'b1;
    tick();
    chk("swap_c", 32'(c_out), 32'h11);
    chk("swap_no_err", 32'(err), 32'h0);
    read_b(rd);
    chk("swap_b", 32'(rd), 32'h22);

    // Conflict: clear beats sum, and the error flag is sticky until reset.
    clr_b = 1'b1;
    sum = 1'b1;
    tick();
    chk("conflict_err", 32'(err), 32'h1);
    read_b(rd);
    chk("conflict_b", 32'(rd), 32'h0);
    repeat (3) tick();
    chk("conflict_sticky", 32'(err), 32'h1);
    resetn = 1'b0;
    #1;
    chk("conflict_rst", 32'(err), 32'h0);
    resetn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
